// File: rtl/popcount_arb_pkg.sv
// Shared types and default sizing for the popcount arbiter slice.
package popcount_arb_pkg;

  localparam int N_REQ_DEF   = 4;
  localparam int WIDTH_DEF   = 32;
  localparam int LATENCY_DEF = 3;

  localparam int CNT_W = $clog2(WIDTH_DEF) + 1;
  localparam int ID_W  = $clog2(N_REQ_DEF);

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/popcount_arbiter_rr_arbiter.sv
// N-way round-robin arbiter: combinational grant searched from a registered
// pointer, pointer advances past the winner on every grant.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [N-1:0]         req_i,
  output logic [N-1:0]         gnt_o,
  output logic                 gnt_val_o,
  output logic [$clog2(N)-1:0] gnt_id_o
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] ptr_r;
  logic [IW-1:0] ptr_nxt_s;
  logic [N-1:0]  gnt_s;
  logic          found_s;
  logic [IW-1:0] gnt_id_s;
  int            idx_s;

  // First requester at or after the pointer, wrapping modulo N
  always_comb begin
    gnt_s    = '0;
    found_s  = 1'b0;
    gnt_id_s = '0;
    idx_s    = 0;
    for (int k = 0; k < N; k++) begin
      idx_s = (int'(ptr_r) + k) % N;
      if (!found_s && req_i[idx_s]) begin
        gnt_s[idx_s] = 1'b1;
        gnt_id_s     = IW'(idx_s);
        found_s      = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  always_comb begin
    ptr_nxt_s = ptr_r;
    if (found_s) begin
      if (gnt_id_s == IW'(N - 1)) begin
        ptr_nxt_s = '0;
      end else begin
        ptr_nxt_s = gnt_id_s + IW'(1);
      end
    end else begin
      ptr_nxt_s = ptr_r;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr_r <= '0;
    end else begin
      ptr_r <= ptr_nxt_s;
    end
  end

  assign gnt_o     = gnt_s;
  assign gnt_val_o = found_s;
  assign gnt_id_o  = gnt_id_s;

endmodule

// File: rtl/popcount_arbiter.sv
// Shares one fixed-latency popcount pipeline among N_REQ requesters and
// returns each count tagged with the ID of the requester that issued it.
module popcount_arbiter
  import popcount_arb_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int WIDTH   = WIDTH_DEF,
  parameter int LATENCY = LATENCY_DEF
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic [N_REQ-1:0]              en_mask_i,
  input  logic [N_REQ*WIDTH-1:0]        req_data_i,
  input  logic [N_REQ-1:0]              req_val_i,
  output logic [N_REQ-1:0]              req_ready_o,
  output logic [WIDTH-1:0]              pc_data_o,
  output logic                          pc_val_o,
  input  logic [$clog2(WIDTH):0]        pc_data_i,
  input  logic                          pc_val_i,
  output logic [$clog2(WIDTH):0]        res_data_o,
  output logic [$clog2(N_REQ)-1:0]      res_id_o,
  output logic                          res_val_o,
  output logic [$clog2(LATENCY+2)-1:0]  inflight_o,
  output logic                          err_o
);

  localparam int IDW   = $clog2(N_REQ);
  localparam int CW    = $clog2(WIDTH) + 1;
  localparam int INF_W = $clog2(LATENCY + 2);

  logic [N_REQ-1:0] elig_s;
  logic [N_REQ-1:0] gnt_s;
  logic             gnt_val_s;
  logic [IDW-1:0]   gnt_id_s;
  logic [WIDTH-1:0] sel_data_s;

  logic             pc_val_r;
  logic [WIDTH-1:0] pc_data_r;
  logic [IDW-1:0]   pc_id_r;

  tag_t             tag_r [LATENCY];
  tag_t             tail_s;

  logic             res_val_r;
  logic [CW-1:0]    res_data_r;
  logic [IDW-1:0]   res_id_r;
  logic [INF_W-1:0] inflight_r;
  logic [INF_W-1:0] inflight_nxt_s;
  logic             err_r;

  assign elig_s = req_val_i & en_mask_i;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .req_i     (elig_s),
    .gnt_o     (gnt_s),
    .gnt_val_o (gnt_val_s),
    .gnt_id_o  (gnt_id_s)
  );

  assign req_ready_o = gnt_s;

  always_comb begin
    sel_data_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_s[i]) begin
        sel_data_s = req_data_i[i*WIDTH +: WIDTH];
      end else begin
        sel_data_s = sel_data_s;
      end
    end
  end

  // Issue stage: data and ID carry no reset, only the valid does
  always_ff @(posedge clk_i) begin
    pc_data_r <= sel_data_s;
    pc_id_r   <= gnt_id_s;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pc_val_r <= 1'b0;
    end else begin
      pc_val_r <= gnt_val_s;
    end
  end

  // Tag line mirrors the counter latency so its tail lines up with pc_val_i
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < LATENCY; i++) begin
        tag_r[i] <= '0;
      end
    end else begin
      tag_r[0] <= {pc_val_r, pc_id_r};
      for (int i = 1; i < LATENCY; i++) begin
        tag_r[i] <= tag_r[i-1];
      end
    end
  end

  assign tail_s = tag_r[LATENCY-1];

  always_comb begin
    inflight_nxt_s = inflight_r;
    case ({gnt_val_s, tail_s.valid})
      2'b10:   inflight_nxt_s = inflight_r + INF_W'(1);
      2'b01:   inflight_nxt_s = inflight_r - INF_W'(1);
      default: inflight_nxt_s = inflight_r;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      res_val_r  <= 1'b0;
      inflight_r <= '0;
      err_r      <= 1'b0;
    end else begin
      res_val_r  <= pc_val_i & tail_s.valid;
      inflight_r <= inflight_nxt_s;
      err_r      <= err_r | (pc_val_i != tail_s.valid);
    end
  end

  always_ff @(posedge clk_i) begin
    res_data_r <= pc_data_i;
    res_id_r   <= tail_s.id;
  end

  assign pc_val_o   = pc_val_r;
  assign pc_data_o  = pc_data_r;
  assign res_val_o  = res_val_r;
  assign res_data_o = res_data_r;
  assign res_id_o   = res_id_r;
  assign inflight_o = inflight_r;
  assign err_o      = err_r;

endmodule

// File: tb/tb_popcount_arbiter.sv
// Directed bench for popcount_arbiter with a 3-cycle popcount counter model.
module tb_popcount_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  en_mask;
  logic [127:0] req_data;
  logic [3:0]  req_val;
  logic [3:0]  req_ready;
  logic [31:0] pc_data_o;
  logic        pc_val_o;
  logic [5:0]  pc_data_i;
  logic        pc_val_i;
  logic [5:0]  res_data;
  logic [1:0]  res_id;
  logic        res_val;
  logic [2:0]  inflight;
  logic        err;
  logic        inject;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] dat [4];
  logic [5:0]  cnt [4];
  int          exp_g [16];
  logic [3:0]  msk [16];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  popcount_arbiter dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .en_mask_i   (en_mask),
    .req_data_i  (req_data),
    .req_val_i   (req_val),
    .req_ready_o (req_ready),
    .pc_data_o   (pc_data_o),
    .pc_val_o    (pc_val_o),
    .pc_data_i   (pc_data_i),
    .pc_val_i    (pc_val_i),
    .res_data_o  (res_data),
    .res_id_o    (res_id),
    .res_val_o   (res_val),
    .inflight_o  (inflight),
    .err_o       (err)
  );

  // Counter model: 3-cycle latency popcount, reset together with the arbiter
  logic [2:0] mv;
  logic [5:0] md [3];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mv <= 3'b000;
    end else begin
      mv    <= {mv[1:0], pc_val_o};
      md[0] <= 6'($countones(pc_data_o));
      md[1] <= md[0];
      md[2] <= md[1];
    end
  end
  assign pc_val_i  = mv[2] | inject;
  assign pc_data_i = md[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    req_val = 4'h0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic run_stream(input int n_iss, input int n_cyc);
    for (int t = 0; t < n_cyc; t++) begin
      @(posedge clk); #1;
      req_val = (t < n_iss) ? 4'hF : 4'h0;
      en_mask = (t < n_iss) ? msk[t] : 4'hF;
      @(negedge clk);
      chk("stream_ready", {28'd0, req_ready}, (t < n_iss) ? (32'd1 << exp_g[t]) : 32'd0);
      if (t >= 1 && t <= n_iss) begin
        chk("stream_pc_data", pc_data_o, dat[exp_g[t-1]]);
      end
      if (t == 5) begin
        chk("stream_inflight_full", {29'd0, inflight}, 32'd4);
      end
      chk("stream_res_val", {31'd0, res_val}, (t >= 5 && t < n_iss + 5) ? 32'd1 : 32'd0);
      if (t >= 5 && t < n_iss + 5) begin
        chk("stream_res_id", {30'd0, res_id}, exp_g[t-5]);
        chk("stream_res_data", {26'd0, res_data}, {26'd0, cnt[exp_g[t-5]]});
      end
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    en_mask  = 4'h0;
    req_val  = 4'h0;
    req_data = 128'd0;
    inject   = 1'b0;
    dat[0] = 32'h0000_0000; cnt[0] = 6'd0;
    dat[1] = 32'hFFFF_FFFF; cnt[1] = 6'd32;
    dat[2] = 32'h8000_0000; cnt[2] = 6'd1;
    dat[3] = 32'h1234_5678; cnt[3] = 6'd13;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pc_val", {31'd0, pc_val_o}, 32'd0);
    chk("rst_res_val", {31'd0, res_val}, 32'd0);
    chk("rst_inflight", {29'd0, inflight}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_ready", {28'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single request from requester 2
    @(posedge clk); #1;
    en_mask = 4'hF;
    req_val = 4'b0100;
    req_data[95:64] = 32'hF0F0_0001;
    @(negedge clk);
    chk("t1_ready", {28'd0, req_ready}, 32'h4);
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      req_val = 4'h0;
      @(negedge clk);
      if (c == 1) begin
        chk("t1_pc_val", {31'd0, pc_val_o}, 32'd1);
        chk("t1_pc_data", pc_data_o, 32'hF0F0_0001);
      end
      chk("t1_inflight", {29'd0, inflight}, (c <= 4) ? 32'd1 : 32'd0);
      chk("t1_res_val", {31'd0, res_val}, (c == 5) ? 32'd1 : 32'd0);
      if (c == 5) begin
        chk("t1_res_id", {30'd0, res_id}, 32'd2);
        chk("t1_res_data", {26'd0, res_data}, 32'd9);
      end
    end

    // All requesters streaming from pointer 0, data 0 / ones / single bit / mixed
    do_reset();
    req_data = {dat[3], dat[2], dat[1], dat[0]};
    for (int i = 0; i < 8; i++) begin
      exp_g[i] = i % 4;
      msk[i]   = 4'hF;
    end
    run_stream(8, 14);

    // Requester 2 masked, then unmasked once the pointer has moved past 1
    exp_g[0] = 0; exp_g[1] = 1; exp_g[2] = 3; exp_g[3] = 0; exp_g[4] = 1;
    exp_g[5] = 3; exp_g[6] = 0; exp_g[7] = 1; exp_g[8] = 2; exp_g[9] = 3;
    for (int i = 0; i < 10; i++) begin
      msk[i] = (i < 8) ? 4'b1011 : 4'hF;
    end
    run_stream(10, 16);
    @(negedge clk);
    chk("t3_err_clean", {31'd0, err}, 32'd0);

    // Stray counter valid in an empty slot
    @(posedge clk); #1;
    inject = 1'b1;
    @(negedge clk);
    chk("t5_err_before", {31'd0, err}, 32'd0);
    @(posedge clk); #1;
    inject = 1'b0;
    @(negedge clk);
    chk("t5_err_set", {31'd0, err}, 32'd1);
    chk("t5_no_res", {31'd0, res_val}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t5_err_sticky", {31'd0, err}, 32'd1);
      chk("t5_no_res_later", {31'd0, res_val}, 32'd0);
    end

    // Reset with three operations in flight
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      req_val = 4'hF;
      @(negedge clk);
      chk("t6_ready", {28'd0, req_ready}, 32'd1 << c);
    end
    @(posedge clk); #1;
    req_val = 4'h0;
    @(negedge clk);
    chk("t6_inflight3", {29'd0, inflight}, 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_pc_val", {31'd0, pc_val_o}, 32'd0);
    chk("t6_rst_res_val", {31'd0, res_val}, 32'd0);
    chk("t6_rst_inflight", {29'd0, inflight}, 32'd0);
    chk("t6_rst_err", {31'd0, err}, 32'd0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("t6_no_stale_res", {31'd0, res_val}, 32'd0);
      chk("t6_no_err", {31'd0, err}, 32'd0);
    end
    @(posedge clk); #1;
    req_val = 4'hF;
    @(negedge clk);
    chk("t6_first_grant", {28'd0, req_ready}, 32'd1);
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      req_val = 4'h0;
      @(negedge clk);
      chk("t6_res_val", {31'd0, res_val}, (c == 5) ? 32'd1 : 32'd0);
      if (c == 5) begin
        chk("t6_res_id", {30'd0, res_id}, 32'd0);
        chk("t6_res_data", {26'd0, res_data}, 32'd0);
      end
    end
    chk("t6_err_final", {31'd0, err}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
